approx_err_monitor: RTL and testbench

Sequential error-statistics monitor sitting directly downstream of the 6-bit approximate adder. Every valid cycle it takes the adder's operands A, B and its approximate sum Y, recomputes the exact sum, and forms the absolute error. Over a measurement window of 2^N_LOG2 samples it accumulates three statistics: the mismatch count, the maximum absolute error and the sum of absolute errors. It reports them with a done pulse, giving on-chip characterisation of any approximation level of the adder.

---
 rtl/approx_mon_pkg.sv | 22 ++
 rtl/approx_err_calc.sv | 36 +++
 rtl/approx_err_monitor.sv | 183 ++++++++++++++++++
 tb/tb_approx_err_monitor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mon_pkg.sv
// -----------------------------------------------------------------------------
// approx_mon_pkg
// Shared definitions for the approximate-adder error monitor:
//   - state_t      : window FSM states (IDLE, RUN, DRAIN, DONE)
//   - W_DEFAULT    : default adder operand width
//   - N_LOG2_DEFAULT : default log2 of the measurement window length
//   - DRAIN_CYCLES : cycles spent flushing the two-stage pipeline
// -----------------------------------------------------------------------------
package approx_mon_pkg;

    localparam int W_DEFAULT      = 6;
    localparam int N_LOG2_DEFAULT = 8;
    localparam int DRAIN_CYCLES   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/approx_err_calc.sv
// -----------------------------------------------------------------------------
// approx_err_calc
// Combinational exact-sum / absolute-error stage.
//   a, b     in  W     : adder operands
//   y        in  W+1   : approximate sum produced by the adder
//   abs_err  out W+1   : |(a + b) - y|
//   mismatch out 1     : abs_err != 0
// The approximate sum can overshoot the exact sum, so the difference is taken
// signed at W+2 bits before the magnitude is formed.
// -----------------------------------------------------------------------------
module approx_err_calc #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W:0]   y,
    output logic [W:0]   abs_err,
    output logic         mismatch
);

    logic [W+1:0] exact;
    logic [W+1:0] diff;

    always_comb begin
        exact = (W+2)'(a) + (W+2)'(b);
        diff  = exact - (W+2)'(y);
        // |diff| always fits in W+1 bits, so negating the low bits is enough.
        if (diff[W+1]) begin
            abs_err = ~diff[W:0] + (W+1)'(1);
        end else begin
            abs_err = diff[W:0];
        end
        mismatch = |abs_err;
    end

endmodule

// File: rtl/approx_err_monitor.sv
// -----------------------------------------------------------------------------
// approx_err_monitor
// Error-statistics monitor for an approximate adder. Over a window of
// 2^N_LOG2 accepted samples it accumulates mismatch count, maximum absolute
// error and sum of absolute errors, then pulses done.
//   clk, rst (sync, active-high)
//   start     in  1          : begin a window from IDLE or DONE
//   in_valid  in  1          : A/B/Y carry a sample (only used in RUN)
//   A, B      in  W          : adder operands
//   Y         in  W+1        : approximate sum
//   busy      out 1          : RUN or DRAIN
//   done      out 1          : one-cycle pulse, results final
//   err_cnt   out N_LOG2+1   : samples with Y != A+B
//   max_err   out W+1        : largest absolute error
//   sum_err   out W+1+N_LOG2 : sum of absolute errors
// Pipeline: stage 1 registers the sample, stage 2 registers abs_err/mismatch,
// accumulators update one edge later.
// -----------------------------------------------------------------------------
module approx_err_monitor
    import approx_mon_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int N_LOG2 = N_LOG2_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [W-1:0]          A,
    input  logic [W-1:0]          B,
    input  logic [W:0]            Y,
    output logic                  busy,
    output logic                  done,
    output logic [N_LOG2:0]       err_cnt,
    output logic [W:0]            max_err,
    output logic [W+N_LOG2:0]     sum_err
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t              state_q, state_d;
    logic [N_LOG2-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]       drain_cnt_q, drain_cnt_d;

    logic                s1_valid_q, s1_valid_d;
    logic [W-1:0]        s1_a_q, s1_a_d;
    logic [W-1:0]        s1_b_q, s1_b_d;
    logic [W:0]          s1_y_q, s1_y_d;

    logic                s2_valid_q, s2_valid_d;
    logic [W:0]          s2_abs_q, s2_abs_d;
    logic                s2_mis_q, s2_mis_d;

    logic [N_LOG2:0]     err_cnt_q, err_cnt_d;
    logic [W:0]          max_err_q, max_err_d;
    logic [W+N_LOG2:0]   sum_err_q, sum_err_d;

    logic                accept;
    logic                launch;
    logic                last_sample;
    logic [W:0]          calc_abs;
    logic                calc_mis;

    assign accept      = (state_q == RUN) && in_valid;
    assign launch      = start && ((state_q == IDLE) || (state_q == DONE));
    // Counter holds accepted-so-far; all ones means this accept completes the window.
    assign last_sample = &cnt_q;

    approx_err_calc #(.W(W)) u_calc (
        .a        (s1_a_q),
        .b        (s1_b_q),
        .y        (s1_y_q),
        .abs_err  (calc_abs),
        .mismatch (calc_mis)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && last_sample) state_d = DRAIN;
            DRAIN:   if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == RUN) || (state_q == DRAIN);
        done = (state_q == DONE);
    end

    // Datapath next values
    always_comb begin
        cnt_d       = cnt_q;
        drain_cnt_d = '0;
        s1_valid_d  = accept;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_y_d      = s1_y_q;
        s2_valid_d  = launch ? 1'b0 : s1_valid_q;
        s2_abs_d    = calc_abs;
        s2_mis_d    = calc_mis;
        err_cnt_d   = err_cnt_q;
        max_err_d   = max_err_q;
        sum_err_d   = sum_err_q;

        if (launch) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (state_q == DRAIN) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
        end

        if (accept) begin
            s1_a_d = A;
            s1_b_d = B;
            s1_y_d = Y;
        end

        if (launch) begin
            err_cnt_d = '0;
            max_err_d = '0;
            sum_err_d = '0;
        end else if (s2_valid_q) begin
            err_cnt_d = err_cnt_q + (N_LOG2+1)'(s2_mis_q);
            sum_err_d = sum_err_q + (W+1+N_LOG2)'(s2_abs_q);
            if (s2_abs_q > max_err_q) begin
                max_err_d = s2_abs_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            drain_cnt_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_y_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_abs_q    <= '0;
            s2_mis_q    <= 1'b0;
            err_cnt_q   <= '0;
            max_err_q   <= '0;
            sum_err_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            drain_cnt_q <= drain_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_y_q      <= s1_y_d;
            s2_valid_q  <= s2_valid_d;
            s2_abs_q    <= s2_abs_d;
            s2_mis_q    <= s2_mis_d;
            err_cnt_q   <= err_cnt_d;
            max_err_q   <= max_err_d;
            sum_err_q   <= sum_err_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign max_err = max_err_q;
    assign sum_err = sum_err_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// -----------------------------------------------------------------------------
// tb_approx_err_monitor
// Directed bench for approx_err_monitor: a table of constant-sample windows
// with hand-computed statistics, plus sequences for random exact streams,
// gapped valid with ignored start, mid-window reset and back-to-back windows.
// -----------------------------------------------------------------------------
module tb_approx_err_monitor;

    localparam int W  = 6;
    localparam int NL = 8;
    localparam int NS = 1 << NL;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [W:0]    Y;
    logic          busy;
    logic          done;
    logic [NL:0]   err_cnt;
    logic [W:0]    max_err;
    logic [W+NL:0] sum_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_cnt, m_max, m_sum, m_acc;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   y;
        bit           gap;
        int           ec;
        int           mx;
        int           sm;
    } vec_t;

    vec_t vecs [7];

    approx_err_monitor #(.W(W), .N_LOG2(NL)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .Y        (Y),
        .busy     (busy),
        .done     (done),
        .err_cnt  (err_cnt),
        .max_err  (max_err),
        .sum_err  (sum_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ref_abs(input int a, input int b, input int y);
        int d;
        d = a + b - y;
        return (d < 0) ? -d : d;
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_max = 0; m_sum = 0; m_acc = 0;
    endtask

    // One cycle of stimulus; on valid cycles the sample is accepted at this edge.
    task automatic feed(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] y, input bit v);
        int e;
        A = a; B = b; Y = y; in_valid = v;
        step();
        if (v) begin
            e = ref_abs(int'(a), int'(b), int'(y));
            if (e != 0) m_cnt++;
            if (e > m_max) m_max = e;
            m_sum += e;
            m_acc++;
        end
        if (m_acc < NS) begin
            chk("busy_in_run", busy, 1);
            chk("no_early_done", done, 0);
        end
    endtask

    task automatic start_window();
        start = 1'b1; in_valid = 1'b0;
        step();
        start = 1'b0;
        model_clear();
        chk("busy_after_start", busy, 1);
        chk("err_cnt_cleared", err_cnt, 0);
        chk("max_err_cleared", max_err, 0);
        chk("sum_err_cleared", sum_err, 0);
    endtask

    // Called right after the edge that accepted the last sample (edge k).
    task automatic finish(input string nm, input int ec, input int mx, input int sm,
                          input bit hold_start);
        in_valid = 1'b0;
        step();  // edge k+1
        chk({nm, "_drain_done"}, done, 0);
        chk({nm, "_drain_busy"}, busy, 1);
        step();  // edge k+2
        chk({nm, "_done"}, done, 1);
        chk({nm, "_done_busy"}, busy, 0);
        chk({nm, "_err_cnt"}, err_cnt, ec);
        chk({nm, "_max_err"}, max_err, mx);
        chk({nm, "_sum_err"}, sum_err, sm);
        if (!hold_start) begin
            step();
            chk({nm, "_done_pulse"}, done, 0);
            chk({nm, "_idle_busy"}, busy, 0);
            chk({nm, "_hold_sum"}, sum_err, sm);
        end
    endtask

    task automatic random_exact_window();
        logic [W-1:0] a, b;
        for (int i = 0; i < NS; i++) begin
            a = W'($urandom_range(0, 63));
            b = W'($urandom_range(0, 63));
            feed(a, b, {1'b0, a} + {1'b0, b}, 1'b1);
        end
    endtask

    task automatic random_mixed_samples(input int n);
        logic [W-1:0] a, b;
        logic [W:0]   y;
        for (int i = 0; i < n; i++) begin
            a = W'($urandom_range(0, 63));
            b = W'($urandom_range(0, 63));
            y = (W+1)'($urandom_range(0, 127));
            feed(a, b, y, 1'b1);
        end
    endtask

    initial begin
        vecs[0] = '{6'd1,  6'd1,  7'd1,   1'b0, 256, 1,   256};
        vecs[1] = '{6'd16, 6'd16, 7'd48,  1'b0, 256, 16,  4096};
        vecs[2] = '{6'd63, 6'd63, 7'd126, 1'b0, 0,   0,   0};
        vecs[3] = '{6'd0,  6'd0,  7'd127, 1'b0, 256, 127, 32512};
        vecs[4] = '{6'd63, 6'd63, 7'd0,   1'b0, 256, 126, 32256};
        vecs[5] = '{6'd5,  6'd9,  7'd12,  1'b1, 256, 2,   512};
        vecs[6] = '{6'd40, 6'd30, 7'd71,  1'b1, 256, 1,   256};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; A = '0; B = '0; Y = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_max_err", max_err, 0);
        chk("rst_sum_err", sum_err, 0);
        rst = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // Exact random stream: all statistics zero.
        start_window();
        random_exact_window();
        finish("exact", 0, 0, 0, 1'b0);

        // Constant-sample windows with hand-computed results.
        for (int v = 0; v < 7; v++) begin
            start_window();
            for (int i = 0; i < NS; i++) begin
                if (vecs[v].gap) feed(vecs[v].a, vecs[v].b, vecs[v].y, 1'b0);
                feed(vecs[v].a, vecs[v].b, vecs[v].y, 1'b1);
            end
            finish($sformatf("vec%0d", v), vecs[v].ec, vecs[v].mx, vecs[v].sm, 1'b0);
        end

        // Gapped valid with start pulses during RUN (ignored).
        start_window();
        for (int i = 0; i < NS; i++) begin
            start = ((i % 16) == 3);
            feed(W'($urandom_range(0, 63)), W'($urandom_range(0, 63)),
                 (W+1)'($urandom_range(0, 127)), 1'b0);
            start = 1'b0;
            feed(W'($urandom_range(0, 63)), W'($urandom_range(0, 63)),
                 (W+1)'($urandom_range(0, 127)), 1'b1);
        end
        chk("gap_accepted", m_acc, NS);
        finish("gapped", m_cnt, m_max, m_sum, 1'b0);

        // Reset mid-RUN discards the window.
        start_window();
        random_mixed_samples(100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_max_err", max_err, 0);
        chk("midrst_sum_err", sum_err, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_no_done", done, 0);
        end
        start_window();
        random_mixed_samples(NS);
        finish("after_rst", m_cnt, m_max, m_sum, 1'b0);

        // Back-to-back: start held high through DONE.
        start = 1'b1; in_valid = 1'b0;
        step();
        model_clear();
        chk("b2b_busy", busy, 1);
        random_mixed_samples(NS);
        finish("b2b_first", m_cnt, m_max, m_sum, 1'b1);
        step();
        start = 1'b0;
        model_clear();
        chk("b2b_restart_busy", busy, 1);
        chk("b2b_restart_done", done, 0);
        chk("b2b_restart_cleared", err_cnt, 0);
        chk("b2b_restart_sum", sum_err, 0);
        random_mixed_samples(NS);
        finish("b2b_second", m_cnt, m_max, m_sum, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
